// File: rtl/mznm_mem_pkg.sv
// -----------------------------------------------------------------------------
// mznm_mem_pkg
// Shared encodings for the stack/data memory block.
//   op_e    : request opcodes carried on the 2-bit Op port
//   state_e : control FSM states of stack_data_mem
// -----------------------------------------------------------------------------
package mznm_mem_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_PUSH  = 2'b10,
        OP_POP   = 2'b11
    } op_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

endpackage : mznm_mem_pkg

// File: rtl/sp_ram.sv
// -----------------------------------------------------------------------------
// sp_ram
// Word-addressed storage array: one synchronous write port and one
// combinational read port. The owner registers the read data, which gives
// the one-cycle read latency and lets a read see a write from the previous
// cycle without any bypass logic.
// Ports:
//   clk_i    : clock, writes happen on the rising edge
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module sp_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : sp_ram

// File: rtl/stack_data_mem.sv
// -----------------------------------------------------------------------------
// stack_data_mem
// Data memory with a downward-growing hardware stack at the top of the
// address space. After reset the whole array is cleared (INIT), then
// requests are taken one per cycle (IDLE).
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_INIT | clearing Mem[InitCnt] each cycle, no requests accepted
//   ST_IDLE | accepting READ / WRITE / PUSH / POP every cycle
//
// Ports:
//   Clk, Rst          : clock, synchronous active-high reset
//   ReqValid/ReqReady : request handshake
//   Op, Addr, DataIn  : opcode, READ/WRITE address, WRITE/PUSH data
//   RspValid, DataOut : READ/POP response, one cycle after acceptance
//   Sp                : next free stack slot
//   Empty, Full       : stack status decoded from Sp
//   Err               : sticky overflow/underflow flag
// -----------------------------------------------------------------------------
module stack_data_mem
    import mznm_mem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 11,
    parameter int STACK_WORDS = 256
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [1:0]        Op,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] DataIn,
    output logic              RspValid,
    output logic [DATA_W-1:0] DataOut,
    output logic [ADDR_W-1:0] Sp,
    output logic              Empty,
    output logic              Full,
    output logic              Err
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] SP_TOP    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] STACK_LIM = ADDR_W'(STACK_WORDS);

    state_e            state_q;
    logic [ADDR_W-1:0] init_cnt_q;
    logic              ready_q;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic              err_q, err_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;

    logic              accept;
    op_e               op;
    logic              is_read, is_write, is_push, is_pop;
    logic              empty, full;
    logic              push_ok, pop_ok;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;

    assign op       = op_e'(Op);
    assign accept   = ReqValid & ready_q;
    assign is_read  = (op == OP_READ);
    assign is_write = (op == OP_WRITE);
    assign is_push  = (op == OP_PUSH);
    assign is_pop   = (op == OP_POP);

    assign empty   = (sp_q == SP_TOP);
    assign full    = ((SP_TOP - sp_q) == STACK_LIM);
    assign push_ok = accept & is_push & ~full;
    assign pop_ok  = accept & is_pop & ~empty;

    // Write port arbitration: INIT clearing owns the port until IDLE.
    // Writes are suppressed while Rst is high so a request presented in the
    // reset cycle leaves no trace.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = sp_q;
        ram_wdata = DataIn;
        if (state_q == ST_INIT) begin
            ram_we    = 1'b1;
            ram_waddr = init_cnt_q;
            ram_wdata = '0;
        end else if (accept && is_write) begin
            ram_we    = 1'b1;
            ram_waddr = Addr;
        end else if (push_ok) begin
            ram_we    = 1'b1;
            ram_waddr = sp_q;
        end
        if (Rst) begin
            ram_we = 1'b0;
        end
    end

    // POP reads the slot just above Sp; it is only used when not empty, so
    // the wrap at SP_TOP never matters.
    assign ram_raddr = is_read ? Addr : (sp_q + 1'b1);

    always_comb begin
        sp_d        = sp_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        data_out_d  = data_out_q;
        if (accept) begin
            unique case (op)
                OP_READ: begin
                    rsp_valid_d = 1'b1;
                    data_out_d  = ram_rdata;
                end
                OP_WRITE: begin
                end
                OP_PUSH: begin
                    if (full) begin
                        err_d = 1'b1;
                    end else begin
                        sp_d = sp_q - 1'b1;
                    end
                end
                OP_POP: begin
                    rsp_valid_d = 1'b1;
                    if (empty) begin
                        err_d      = 1'b1;
                        data_out_d = '0;
                    end else begin
                        sp_d       = sp_q + 1'b1;
                        data_out_d = ram_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            ready_q     <= 1'b0;
            sp_q        <= SP_TOP;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            sp_q        <= sp_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            data_out_q  <= data_out_d;
            unique case (state_q)
                ST_INIT: begin
                    if (init_cnt_q == SP_TOP) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    sp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (Clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign ReqReady = ready_q;
    assign RspValid = rsp_valid_q;
    assign DataOut  = data_out_q;
    assign Sp       = sp_q;
    assign Empty    = empty;
    assign Full     = full;
    assign Err      = err_q;

endmodule : stack_data_mem

// File: tb/tb_stack_data_mem.sv
// -----------------------------------------------------------------------------
// tb_stack_data_mem
// Directed bench for stack_data_mem with a 16-word array and a 3-entry stack.
// A vector table covers read/write/push/pop behaviour; hand-written sequences
// cover INIT length, underflow and reset during INIT / during a read.
// -----------------------------------------------------------------------------
module tb_stack_data_mem;
    import mznm_mem_pkg::*;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int SW = 3;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          ReqValid;
    logic          ReqReady;
    logic [1:0]    Op;
    logic [AW-1:0] Addr;
    logic [DW-1:0] DataIn;
    logic          RspValid;
    logic [DW-1:0] DataOut;
    logic [AW-1:0] Sp;
    logic          Empty;
    logic          Full;
    logic          Err;

    int n_cmp = 0;
    int n_bad = 0;

    stack_data_mem #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .STACK_WORDS (SW)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .ReqValid (ReqValid),
        .ReqReady (ReqReady),
        .Op       (Op),
        .Addr     (Addr),
        .DataIn   (DataIn),
        .RspValid (RspValid),
        .DataOut  (DataOut),
        .Sp       (Sp),
        .Empty    (Empty),
        .Full     (Full),
        .Err      (Err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic          valid;
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          rv;
        logic [DW-1:0] dout;
        logic [AW-1:0] sp;
        logic          err;
        logic          empty;
        logic          full;
    } vec_t;

    vec_t vecs[17];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] o, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        ReqValid = v;
        Op       = o;
        Addr     = a;
        DataIn   = d;
    endtask

    // Releases reset and counts cycles until ReqReady rises; also flags any
    // RspValid seen during INIT.
    task automatic wait_init(input string name);
        int n;
        logic saw_rsp;
        n = 0;
        saw_rsp = 1'b0;
        Rst = 1'b0;
        while (!ReqReady && n < 40) begin
            if (RspValid) saw_rsp = 1'b1;
            tick();
            n++;
        end
        chk({name, "_init_cycles"}, n, 16);
        chk({name, "_rsp_in_init"}, {31'd0, saw_rsp}, 0);
    endtask

    task automatic do_reset();
        drive(1'b0, OP_READ, '0, '0);
        Rst = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        Rst = 1'b1;
        drive(1'b0, OP_READ, '0, '0);

        // op, addr, din -> rv, dout, sp, err, empty, full
        vecs[0]  = '{1'b1, OP_WRITE, 4'd5,  16'hBEEF, 1'b0, 16'h0000, 4'd15, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, OP_READ,  4'd5,  16'h0000, 1'b1, 16'hBEEF, 4'd15, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, OP_READ,  4'd5,  16'h0000, 1'b0, 16'hBEEF, 4'd15, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, OP_PUSH,  4'd0,  16'h1111, 1'b0, 16'hBEEF, 4'd14, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, OP_PUSH,  4'd0,  16'h2222, 1'b0, 16'hBEEF, 4'd13, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, OP_POP,   4'd0,  16'h0000, 1'b1, 16'h2222, 4'd14, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, OP_POP,   4'd0,  16'h0000, 1'b1, 16'h1111, 4'd15, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, OP_READ,  4'd15, 16'h0000, 1'b1, 16'h1111, 4'd15, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, OP_WRITE, 4'd14, 16'hABCD, 1'b0, 16'h1111, 4'd15, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, OP_PUSH,  4'd0,  16'hAAAA, 1'b0, 16'h1111, 4'd14, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, OP_PUSH,  4'd0,  16'hBBBB, 1'b0, 16'h1111, 4'd13, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, OP_PUSH,  4'd0,  16'hCCCC, 1'b0, 16'h1111, 4'd12, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, OP_PUSH,  4'd0,  16'hDDDD, 1'b0, 16'h1111, 4'd12, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b1, OP_READ,  4'd12, 16'h0000, 1'b1, 16'h0000, 4'd12, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b1, OP_POP,   4'd0,  16'h0000, 1'b1, 16'hCCCC, 4'd13, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b1, OP_READ,  4'd14, 16'h0000, 1'b1, 16'hBBBB, 4'd13, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b0, OP_PUSH,  4'd0,  16'h1234, 1'b0, 16'hBBBB, 4'd13, 1'b1, 1'b0, 1'b0};

        // Reset state
        tick();
        tick();
        chk("rst_ready",  {31'd0, ReqReady}, 0);
        chk("rst_sp",     {28'd0, Sp}, 15);
        chk("rst_err",    {31'd0, Err}, 0);
        chk("rst_rv",     {31'd0, RspValid}, 0);
        chk("rst_dout",   {16'd0, DataOut}, 0);
        chk("rst_empty",  {31'd0, Empty}, 1);
        chk("rst_full",   {31'd0, Full}, 0);

        wait_init("boot");

        // Every address reads back as cleared, back-to-back reads
        for (int a = 0; a < 16; a++) begin
            drive(1'b1, OP_READ, AW'(a), '0);
            tick();
            chk($sformatf("clr_rv_%0d", a),   {31'd0, RspValid}, 1);
            chk($sformatf("clr_data_%0d", a), {16'd0, DataOut}, 0);
        end

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].valid, vecs[i].op, vecs[i].addr, vecs[i].din);
            tick();
            chk($sformatf("v%0d_rv", i),    {31'd0, RspValid}, {31'd0, vecs[i].rv});
            chk($sformatf("v%0d_dout", i),  {16'd0, DataOut},  {16'd0, vecs[i].dout});
            chk($sformatf("v%0d_sp", i),    {28'd0, Sp},       {28'd0, vecs[i].sp});
            chk($sformatf("v%0d_err", i),   {31'd0, Err},      {31'd0, vecs[i].err});
            chk($sformatf("v%0d_empty", i), {31'd0, Empty},    {31'd0, vecs[i].empty});
            chk($sformatf("v%0d_full", i),  {31'd0, Full},     {31'd0, vecs[i].full});
        end

        // Underflow: make DataOut nonzero first so the forced 0 is visible
        do_reset();
        chk("rst2_err", {31'd0, Err}, 0);
        wait_init("uf");
        drive(1'b1, OP_WRITE, 4'd3, 16'h7777);
        tick();
        drive(1'b1, OP_READ, 4'd3, '0);
        tick();
        chk("uf_pre_dout", {16'd0, DataOut}, 16'h7777);
        drive(1'b1, OP_POP, 4'd0, '0);
        tick();
        chk("uf_rv",   {31'd0, RspValid}, 1);
        chk("uf_dout", {16'd0, DataOut}, 0);
        chk("uf_err",  {31'd0, Err}, 1);
        chk("uf_sp",   {28'd0, Sp}, 15);
        drive(1'b0, OP_READ, '0, '0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("uf_sticky_%0d", k), {31'd0, Err}, 1);
            chk($sformatf("uf_rv_idle_%0d", k), {31'd0, RspValid}, 0);
        end
        do_reset();
        chk("uf_err_cleared", {31'd0, Err}, 0);

        // Reset 5 cycles into INIT restarts the full clear
        Rst = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("mid_init_ready", {31'd0, ReqReady}, 0);
        Rst = 1'b1;
        tick();
        wait_init("mid");

        // Reset in the cycle a READ is accepted drops the response
        drive(1'b1, OP_WRITE, 4'd9, 16'h5A5A);
        tick();
        drive(1'b1, OP_READ, 4'd9, '0);
        Rst = 1'b1;
        tick();
        drive(1'b0, OP_READ, '0, '0);
        chk("rdrst_rv",    {31'd0, RspValid}, 0);
        chk("rdrst_dout",  {16'd0, DataOut}, 0);
        chk("rdrst_ready", {31'd0, ReqReady}, 0);
        wait_init("rdrst");
        // INIT cleared the word written before the reset
        drive(1'b1, OP_READ, 4'd9, '0);
        tick();
        chk("rdrst_clr_rv",   {31'd0, RspValid}, 1);
        chk("rdrst_clr_data", {16'd0, DataOut}, 0);
        drive(1'b0, OP_READ, '0, '0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_stack_data_mem

// File: doc/stack_data_mem.md
STACK_DATA_MEM -- requirements
Module: stack_data_mem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 11: address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have parameter STACK_WORDS, default 256: maximum stack entries, 1 <= STACK_WORDS < DEPTH.
REQ-004 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port Rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port ReqValid, input, 1 bit: a request is presented this cycle.
REQ-007 The block SHALL have port ReqReady, output, 1 bit: the block accepts a request this cycle.
REQ-008 The block SHALL have port Op, input, 2 bits: 00 READ, 01 WRITE, 10 PUSH, 11 POP.
REQ-009 The block SHALL have port Addr, input, ADDR_W bits: word address for READ and WRITE, ignored for PUSH and POP.
REQ-010 The block SHALL have port DataIn, input, DATA_W bits: write or push data.
REQ-011 The block SHALL have port RspValid, output, 1 bit: DataOut is valid this cycle.
REQ-012 The block SHALL have port DataOut, output, DATA_W bits: read or pop data.
REQ-013 The block SHALL have port Sp, output, ADDR_W bits: current stack pointer, the next free slot; the stack grows downward.
REQ-014 The block SHALL have port Empty, output, 1 bit, and port Full, output, 1 bit: stack status.
REQ-015 The block SHALL have port Err, output, 1 bit: sticky overflow/underflow flag.

Function
REQ-016 The block SHALL have two states, INIT and IDLE; INIT writes 0 to address InitCnt each cycle, InitCnt counting 0..DEPTH-1, and moves to IDLE after writing DEPTH-1.
REQ-017 ReqReady SHALL be 0 in INIT and 1 in IDLE; a request is accepted when ReqValid and ReqReady are both 1.
REQ-018 An accepted WRITE SHALL store DataIn at Mem[Addr] at that rising edge.
REQ-019 An accepted READ SHALL drive RspValid=1 and DataOut=Mem[Addr] in the next cycle (latency 1); a READ issued the cycle after a WRITE to the same address SHALL return the new data.
REQ-020 An accepted PUSH when not Full SHALL write Mem[Sp]=DataIn and decrement Sp by 1; it produces no response.
REQ-021 An accepted POP when not Empty SHALL increment Sp by 1 and drive RspValid=1 with DataOut=Mem[Sp+1] in the next cycle.
REQ-022 Empty SHALL equal (Sp == DEPTH-1); Full SHALL equal (DEPTH-1-Sp == STACK_WORDS); both are combinational from Sp.
REQ-023 A PUSH when Full SHALL not write memory, SHALL leave Sp unchanged, and SHALL set Err.
REQ-024 A POP when Empty SHALL leave Sp unchanged, SHALL set Err, and SHALL drive RspValid=1 with DataOut=0 in the next cycle.
REQ-025 Err SHALL remain 1 until Rst.
REQ-026 RspValid SHALL be 0 in every cycle not covered by REQ-019, REQ-021 or REQ-024; DataOut SHALL hold its last value when RspValid=0.
REQ-027 READ and WRITE SHALL not alter Sp, including when they target stack addresses; there is no address protection.

Reset
REQ-028 When Rst=1 at a rising edge, the block SHALL set state=INIT, InitCnt=0, Sp=DEPTH-1, Err=0, RspValid=0 and DataOut=0.
REQ-029 Rst asserted mid-INIT SHALL restart clearing at address 0.
REQ-030 Rst asserted while a response is pending SHALL drop that response, so RspValid=0 in the cycle after reset.
REQ-031 Memory contents SHALL be defined only through INIT; there are no file preloads.

Structure
REQ-032 The Op encodings (OP_READ, OP_WRITE, OP_PUSH, OP_POP) and the state encodings SHALL live in shared package mznm_mem_pkg.
REQ-033 The storage array SHALL be a single sub-module, sp_ram, with one synchronous write port and one read port, parametrised by DATA_W and ADDR_W.
REQ-034 The control FSM, Sp and Err SHALL reside in stack_data_mem.

Verification
REQ-035 Scenario: with ADDR_W=4, after reset -> ReqReady=0 for 16 cycles, then 1; a READ of every address returns 0.
REQ-036 Scenario: WRITE Addr=5 Data=0xBEEF, then READ Addr=5 in the next cycle -> RspValid=1 and DataOut=0xBEEF exactly one cycle after the READ.
REQ-037 Scenario: PUSH 0x1111 then PUSH 0x2222, then POP and POP -> DataOut 0x2222 then 0x1111, Sp returns to 15, Empty=1, Err=0.
REQ-038 Scenario: with STACK_WORDS=3, four PUSHes -> Sp=12 and Full=1 after the third; the fourth sets Err=1, leaves Sp=12 and does not change Mem[12].
REQ-039 Scenario: POP on an empty stack -> RspValid=1, DataOut=0, Err=1, Sp=15; Err stays 1 until Rst.
REQ-040 Scenario: Rst pulsed 5 cycles into INIT, and separately Rst pulsed in the cycle a READ is accepted -> INIT restarts with a full 16-cycle clear, and no RspValid is seen.
